// File: rtl/class_hvec_pkg.sv
// Shared types and helpers for the class hypervector streaming store.
// Contents: write-operation and FSM state enums, and the derived index-width helper.
package class_hvec_pkg;

  typedef enum logic {
    WR_OVERWRITE = 1'b0,
    WR_XOR       = 1'b1
  } wr_op_e;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_e;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/class_hvec_stream_if.sv
// Bus bundle for class_hvec_stream: request channel, frame output channel
// and the training write port.
//   master : request/write driver and frame consumer
//   slave  : the class hypervector store/streamer
interface class_hvec_stream_if #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_CLASSES        = 8,
  parameter int NUM_FRAMES         = 3
);
  localparam int CLASS_ID_W  = class_hvec_pkg::idx_w(NUM_CLASSES);
  localparam int FRAME_IDX_W = class_hvec_pkg::idx_w(NUM_FRAMES);

  logic                          req_valid;
  logic                          req_ready;
  logic [CLASS_ID_W-1:0]         req_class;
  logic                          req_all;
  logic                          req_err;

  logic                          out_valid;
  logic                          out_ready;
  logic [DI_PARALLEL_W_BITS-1:0] class_vec_out;
  logic [CLASS_ID_W-1:0]         out_class_id;
  logic [FRAME_IDX_W-1:0]        out_frame_index;
  logic                          out_last_frame;
  logic                          out_last_class;

  logic                          wr_en;
  class_hvec_pkg::wr_op_e        wr_op;
  logic [CLASS_ID_W-1:0]         wr_class;
  logic [FRAME_IDX_W-1:0]        wr_frame;
  logic [DI_PARALLEL_W_BITS-1:0] wr_data;

  modport master (
    output req_valid, req_class, req_all, out_ready,
           wr_en, wr_op, wr_class, wr_frame, wr_data,
    input  req_ready, req_err, out_valid, class_vec_out, out_class_id,
           out_frame_index, out_last_frame, out_last_class
  );

  modport slave (
    input  req_valid, req_class, req_all, out_ready,
           wr_en, wr_op, wr_class, wr_frame, wr_data,
    output req_ready, req_err, out_valid, class_vec_out, out_class_id,
           out_frame_index, out_last_frame, out_last_class
  );
endinterface

// File: rtl/class_hvec_store.sv
// NUM_CLASSES x NUM_FRAMES register array holding the class hypervectors.
// Ports:
//   clk, rst_n                      clock, async active-low clear of every word
//   wr_en/wr_op/wr_class/wr_frame/wr_data
//                                   write port (overwrite or XOR-accumulate)
//   rd_class/rd_frame -> rd_data    combinational read port (0 when out of range)
module class_hvec_store
  import class_hvec_pkg::*;
#(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_CLASSES        = 8,
  parameter int NUM_FRAMES         = 3,
  localparam int CLASS_ID_W        = idx_w(NUM_CLASSES),
  localparam int FRAME_IDX_W       = idx_w(NUM_FRAMES)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  wr_op_e                        wr_op,
  input  logic [CLASS_ID_W-1:0]         wr_class,
  input  logic [FRAME_IDX_W-1:0]        wr_frame,
  input  logic [DI_PARALLEL_W_BITS-1:0] wr_data,
  input  logic [CLASS_ID_W-1:0]         rd_class,
  input  logic [FRAME_IDX_W-1:0]        rd_frame,
  output logic [DI_PARALLEL_W_BITS-1:0] rd_data
);

  localparam logic [CLASS_ID_W:0]  NUM_CLASSES_EXT = (CLASS_ID_W+1)'(NUM_CLASSES);
  localparam logic [FRAME_IDX_W:0] NUM_FRAMES_EXT  = (FRAME_IDX_W+1)'(NUM_FRAMES);

  logic [DI_PARALLEL_W_BITS-1:0] mem [NUM_CLASSES][NUM_FRAMES];
  logic wr_hit;
  logic rd_hit;

  // Index widths round up to a power of two, so range must be checked explicitly.
  assign wr_hit = wr_en && ({1'b0, wr_class} < NUM_CLASSES_EXT)
                        && ({1'b0, wr_frame} < NUM_FRAMES_EXT);
  assign rd_hit = ({1'b0, rd_class} < NUM_CLASSES_EXT)
               && ({1'b0, rd_frame} < NUM_FRAMES_EXT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        for (int f = 0; f < NUM_FRAMES; f++) begin
          mem[c][f] <= '0;
        end
      end
    end else if (wr_hit) begin
      if (wr_op == WR_XOR) begin
        mem[wr_class][wr_frame] <= mem[wr_class][wr_frame] ^ wr_data;
      end else begin
        mem[wr_class][wr_frame] <= wr_data;
      end
    end
  end

  // Read returns the pre-write contents during a same-edge write.
  assign rd_data = rd_hit ? mem[rd_class][rd_frame] : '0;

endmodule

// File: rtl/class_hvec_stream.sv
// Writable class hypervector store that streams stored vectors frame by frame
// over a valid/ready channel, either one class or a sweep over all classes.
// Ports:
//   clk, rst_n  clock, async active-low reset (clears storage, returns to idle)
//   bus         class_hvec_stream_if.slave: request, frame output, write port
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | req_ready=1, waiting for a request; no beat on the output
// S_STREAM | output register holds a valid beat; advances on out_ready
module class_hvec_stream
  import class_hvec_pkg::*;
#(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_CLASSES        = 8,
  parameter int NUM_FRAMES         = 3,
  localparam int CLASS_ID_W        = idx_w(NUM_CLASSES),
  localparam int FRAME_IDX_W       = idx_w(NUM_FRAMES)
) (
  input logic                clk,
  input logic                rst_n,
  class_hvec_stream_if.slave bus
);

  localparam logic [CLASS_ID_W:0]    NUM_CLASSES_EXT = (CLASS_ID_W+1)'(NUM_CLASSES);
  localparam logic [CLASS_ID_W-1:0]  LAST_CLASS      = (CLASS_ID_W)'(NUM_CLASSES-1);
  localparam logic [FRAME_IDX_W-1:0] LAST_FRAME      = (FRAME_IDX_W)'(NUM_FRAMES-1);

  state_e state;
  state_e state_nxt;

  logic                          mode_all;
  logic [DI_PARALLEL_W_BITS-1:0] vec_q;
  logic [CLASS_ID_W-1:0]         class_q;
  logic [FRAME_IDX_W-1:0]        frame_q;
  logic                          last_frame_q;
  logic                          last_class_q;
  logic                          err_q;

  logic                          req_in_range;
  logic                          accept;
  logic                          reject;
  logic                          beat_done;
  logic                          load;
  logic                          ld_all;
  logic [CLASS_ID_W-1:0]         ld_class;
  logic [FRAME_IDX_W-1:0]        ld_frame;
  logic                          ld_last_frame;
  logic                          ld_last_class;
  logic [DI_PARALLEL_W_BITS-1:0] rd_data;

  class_hvec_store #(
    .DI_PARALLEL_W_BITS(DI_PARALLEL_W_BITS),
    .NUM_CLASSES       (NUM_CLASSES),
    .NUM_FRAMES        (NUM_FRAMES)
  ) u_store (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (bus.wr_en),
    .wr_op   (bus.wr_op),
    .wr_class(bus.wr_class),
    .wr_frame(bus.wr_frame),
    .wr_data (bus.wr_data),
    .rd_class(ld_class),
    .rd_frame(ld_frame),
    .rd_data (rd_data)
  );

  // Request decode and next (class, frame) address for the output register.
  always_comb begin
    req_in_range = ({1'b0, bus.req_class} < NUM_CLASSES_EXT);
    accept       = (state == S_IDLE) && bus.req_valid && (bus.req_all || req_in_range);
    reject       = (state == S_IDLE) && bus.req_valid && !bus.req_all && !req_in_range;
    // out_valid is always 1 in S_STREAM, so out_ready alone completes a beat.
    beat_done    = (state == S_STREAM) && bus.out_ready;

    ld_all   = mode_all;
    ld_class = class_q;
    ld_frame = frame_q;
    if (state == S_IDLE) begin
      ld_all   = bus.req_all;
      ld_class = bus.req_all ? '0 : bus.req_class;
      ld_frame = '0;
    end else if (frame_q == LAST_FRAME) begin
      // Only reachable in a sweep; the final beat never reloads.
      ld_frame = '0;
      ld_class = class_q + 1'b1;
    end else begin
      ld_frame = frame_q + 1'b1;
    end

    ld_last_frame = (ld_frame == LAST_FRAME);
    ld_last_class = ld_last_frame && (!ld_all || (ld_class == LAST_CLASS));
    load          = accept || (beat_done && !last_class_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept) state_nxt = S_STREAM;
      S_STREAM: if (beat_done && last_class_q) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state == S_IDLE);
    bus.out_valid = (state == S_STREAM);
  end

  // Output register doubles as the class/frame counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_all     <= 1'b0;
      vec_q        <= '0;
      class_q      <= '0;
      frame_q      <= '0;
      last_frame_q <= 1'b0;
      last_class_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        mode_all <= bus.req_all;
      end
      if (load) begin
        vec_q        <= rd_data;
        class_q      <= ld_class;
        frame_q      <= ld_frame;
        last_frame_q <= ld_last_frame;
        last_class_q <= ld_last_class;
      end
    end
  end

  assign bus.req_err         = err_q;
  assign bus.class_vec_out   = vec_q;
  assign bus.out_class_id    = class_q;
  assign bus.out_frame_index = frame_q;
  assign bus.out_last_frame  = last_frame_q;
  assign bus.out_last_class  = last_class_q;

endmodule
